bmc_half_bit_sampler: RTL and testbench

- Recovers half-bit timing from the asynchronous, oversampled optical line and emits one sampled level per Biphase Mark half-bit, with a single-cycle valid strobe.
- Sits directly upstream of the BMC decoder: `o_bit`/`valid_out` drive its serial half-bit input and valid.
- Tracks line edges to stay phase-aligned and reports lock and edge errors.
- Does not pair half-bits into bits; dibit pairing is downstream.

---
 rtl/bmc_half_bit_sampler.sv | 168 ++++++++++++++++
 tb/tb_bmc_half_bit_sampler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmc_half_bit_sampler.sv
// Half-bit timing recovery for the oversampled Biphase Mark optical line.
// Synchronizes the raw line, tracks transitions with a phase counter, and
// strobes one mid-half-bit sample per half-bit once locked.
// Ports:
//   clk, rst      - system clock, asynchronous active-high reset
//   i_line        - raw comparator level (asynchronous to clk)
//   i_enable      - synchronous enable; low forces SEARCH
//   o_bit         - sampled half-bit level, held between strobes
//   valid_out     - one-cycle strobe per half-bit while locked
//   o_locked      - high while in LOCKED
//   o_edge_error  - one-cycle pulse on out-of-window edge or silence timeout
module bmc_half_bit_sampler #(
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned LOCK_EDGES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  input  logic i_enable,
  output logic o_bit,
  output logic valid_out,
  output logic o_locked,
  output logic o_edge_error
);

  localparam int unsigned PH_W    = $clog2(OVERSAMPLE);
  localparam int unsigned SIL_W   = $clog2(2 * OVERSAMPLE + 3);
  localparam int unsigned GOOD_W  = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES) : 1;

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]   PH_MID    = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
  localparam logic [SIL_W-1:0]  SIL_TO    = SIL_W'(2 * OVERSAMPLE + 2);
  localparam logic [SIL_W-1:0]  SIL_ONE   = SIL_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_EDGES - 1);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            st, st_nxt;
  logic              s1, s2, s3;
  logic [PH_W-1:0]   ph, ph_nxt, ph_inc;
  logic [SIL_W-1:0]  sil, sil_nxt, sil_inc;
  logic [GOOD_W-1:0] good, good_nxt;
  logic              line_edge, on_time, timeout;
  logic              err_nxt, smp;

  // Transition detect on the synchronized line (both polarities)
  assign line_edge = s2 ^ s3;
  // +/-1 cycle window around the expected half-bit boundary
  assign on_time   = (ph == PH_LAST) || (ph == '0) || (ph == PH_ONE);
  // An edge in the timeout cycle wins over the timeout
  assign timeout   = (sil == SIL_TO) && !line_edge;
  assign ph_inc    = (ph == PH_LAST) ? '0 : ph + PH_ONE;
  assign sil_inc   = (sil == SIL_TO) ? sil : sil + SIL_ONE;

  // State register, synchronizer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= SEARCH;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      ph           <= '0;
      sil          <= '0;
      good         <= '0;
      o_bit        <= 1'b0;
      valid_out    <= 1'b0;
      o_locked     <= 1'b0;
      o_edge_error <= 1'b0;
    end else begin
      st           <= st_nxt;
      s1           <= i_line;
      s2           <= s1;
      s3           <= s2;
      ph           <= ph_nxt;
      sil          <= sil_nxt;
      good         <= good_nxt;
      o_bit        <= smp ? s2 : o_bit;
      valid_out    <= smp;
      o_locked     <= (st_nxt == LOCKED);
      o_edge_error <= err_nxt;
    end
  end

  // Next-state, counter and strobe logic; an edge realigns so the edge
  // cycle itself is phase 0 and silence count 0
  always_comb begin
    st_nxt   = st;
    ph_nxt   = ph_inc;
    sil_nxt  = sil_inc;
    good_nxt = good;
    err_nxt  = 1'b0;
    smp      = 1'b0;
    if (!i_enable) begin
      st_nxt   = SEARCH;
      ph_nxt   = '0;
      sil_nxt  = '0;
      good_nxt = '0;
    end else begin
      case (st)
        SEARCH: begin
          ph_nxt   = '0;
          sil_nxt  = '0;
          good_nxt = '0;
          if (line_edge) begin
            st_nxt  = ACQUIRE;
            ph_nxt  = PH_ONE;
            sil_nxt = SIL_ONE;
          end
        end
        ACQUIRE: begin
          if (line_edge) begin
            ph_nxt  = PH_ONE;
            sil_nxt = SIL_ONE;
            if (on_time) begin
              if (good == GOOD_LAST) begin
                st_nxt   = LOCKED;
                good_nxt = '0;
              end else begin
                good_nxt = good + GOOD_ONE;
              end
            end else begin
              good_nxt = '0;
              err_nxt  = 1'b1;
            end
          end else if (timeout) begin
            st_nxt   = SEARCH;
            ph_nxt   = '0;
            sil_nxt  = '0;
            good_nxt = '0;
            err_nxt  = 1'b1;
          end
        end
        LOCKED: begin
          if (line_edge) begin
            ph_nxt  = PH_ONE;
            sil_nxt = SIL_ONE;
            if (!on_time) begin
              st_nxt   = ACQUIRE;
              good_nxt = '0;
              err_nxt  = 1'b1;
            end
          end else if (timeout) begin
            st_nxt   = SEARCH;
            ph_nxt   = '0;
            sil_nxt  = '0;
            good_nxt = '0;
            err_nxt  = 1'b1;
          end else if (ph == PH_MID) begin
            smp = 1'b1;
          end
        end
        default: begin
          st_nxt   = SEARCH;
          ph_nxt   = '0;
          sil_nxt  = '0;
          good_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmc_half_bit_sampler.sv
// Directed bench for bmc_half_bit_sampler (OVERSAMPLE=8, LOCK_EDGES=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_bmc_half_bit_sampler;

  logic clk = 1'b0;
  logic rst;
  logic i_line;
  logic i_enable;
  logic o_bit;
  logic valid_out;
  logic o_locked;
  logic o_edge_error;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   err_cnt = 0;
  logic mon_bits [$];
  int   mon_cyc  [$];
  logic pat [8];

  bmc_half_bit_sampler #(.OVERSAMPLE(8), .LOCK_EDGES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_line       (i_line),
    .i_enable     (i_enable),
    .o_bit        (o_bit),
    .valid_out    (valid_out),
    .o_locked     (o_locked),
    .o_edge_error (o_edge_error)
  );

  always #5 clk = ~clk;

  // Strobe and error recorder, sampled between clock edges
  always begin
    @(posedge clk);
    #3;
    cyc = cyc + 1;
    if (valid_out === 1'b1) begin
      mon_bits.push_back(o_bit);
      mon_cyc.push_back(cyc);
    end
    if (o_edge_error === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic clear_mon();
    mon_bits.delete();
    mon_cyc.delete();
    err_cnt = 0;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b1;
    i_enable = 1'b1;
    i_line = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 0) i_line = ~i_line;
      @(negedge clk);
      if ({o_bit, valid_out, o_locked, o_edge_error} !== 4'b0000) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL reset_outputs: %0d nonzero cycles, expected 0", bad); end
    tests++;
    if (mon_bits.size() !== 0) begin fails++; $display("FAIL reset_strobes: got %0d expected 0", mon_bits.size()); end
    i_line = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (o_locked !== 1'b0) begin fails++; $display("FAIL reset_locked_after: got %b expected 0", o_locked); end
    tests++;
    if (o_edge_error !== 1'b0) begin fails++; $display("FAIL reset_err_after: got %b expected 0", o_edge_error); end
  endtask

  // 32 half-bits of the 1,0,1,1,0,1,0,0 pattern; lock lands on half-bit 5
  task automatic run_stream(input bit jitter);
    int len;
    int bad_gap;
    clear_mon();
    for (int h = 0; h < 32; h++) begin
      len = jitter ? ((h % 2 == 0) ? 7 : 9) : 8;
      i_line = pat[h % 8];
      for (int c = 1; c <= len; c++) begin
        @(negedge clk);
        if (h == 5 && c == 2) begin
          tests++;
          if (o_locked !== 1'b0) begin fails++; $display("FAIL stream_lock_early(j=%0d): got %b expected 0", jitter, o_locked); end
        end
        if (h == 5 && c == 3) begin
          tests++;
          if (o_locked !== 1'b1) begin fails++; $display("FAIL stream_lock_rise(j=%0d): got %b expected 1", jitter, o_locked); end
        end
      end
    end
    tests++;
    if (err_cnt !== 0) begin fails++; $display("FAIL stream_errors(j=%0d): got %0d expected 0", jitter, err_cnt); end
    tests++;
    if (mon_bits.size() !== 27) begin fails++; $display("FAIL stream_strobe_count(j=%0d): got %0d expected 27", jitter, mon_bits.size()); end
    for (int i = 0; i < 27 && i < mon_bits.size(); i++) begin
      tests++;
      if (mon_bits[i] !== pat[(i + 5) % 8]) begin
        fails++; $display("FAIL stream_bit%0d(j=%0d): got %b expected %b", i, jitter, mon_bits[i], pat[(i + 5) % 8]);
      end
    end
    if (!jitter) begin
      bad_gap = 0;
      for (int i = 1; i < mon_cyc.size(); i++) if (mon_cyc[i] - mon_cyc[i-1] != 8) bad_gap++;
      tests++;
      if (bad_gap !== 0) begin fails++; $display("FAIL stream_spacing: %0d gaps not 8, expected 0", bad_gap); end
    end
  endtask

  task automatic test_clean();
    run_stream(1'b0);
  endtask

  task automatic test_jitter();
    run_stream(1'b1);
  endtask

  // Line held low after the clean stream; last edge was at the start of half-bit 30
  task automatic test_dead_line();
    repeat (4) @(negedge clk);
    tests++;
    if (o_locked !== 1'b1 || o_edge_error !== 1'b0) begin
      fails++; $display("FAIL dead_before: locked=%b err=%b expected 1/0", o_locked, o_edge_error);
    end
    @(negedge clk);
    tests++;
    if (o_edge_error !== 1'b1) begin fails++; $display("FAIL dead_err_pulse: got %b expected 1", o_edge_error); end
    tests++;
    if (o_locked !== 1'b0) begin fails++; $display("FAIL dead_unlock: got %b expected 0", o_locked); end
    @(negedge clk);
    tests++;
    if (o_edge_error !== 1'b0) begin fails++; $display("FAIL dead_err_single: got %b expected 0", o_edge_error); end
    repeat (30) @(negedge clk);
    tests++;
    if (err_cnt !== 1) begin fails++; $display("FAIL dead_err_count: got %0d expected 1", err_cnt); end
    tests++;
    if (mon_bits.size() !== 27) begin fails++; $display("FAIL dead_no_strobe: got %0d expected 27", mon_bits.size()); end
  endtask

  task automatic test_glitch();
    logic lv [10];
    int   ln [10];
    logic exp_bits [5];
    lv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ln = '{8, 3, 8, 8, 8, 8, 8, 8, 8, 8};
    exp_bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    clear_mon();
    for (int g = 0; g < 10; g++) begin
      i_line = lv[g];
      for (int c = 1; c <= ln[g]; c++) begin
        @(negedge clk);
        if (g == 2 && c == 2) begin
          tests++;
          if (o_locked !== 1'b1 || o_edge_error !== 1'b0) begin
            fails++; $display("FAIL glitch_pre: locked=%b err=%b expected 1/0", o_locked, o_edge_error);
          end
        end
        if (g == 2 && c == 3) begin
          tests++;
          if (o_locked !== 1'b0 || o_edge_error !== 1'b1) begin
            fails++; $display("FAIL glitch_hit: locked=%b err=%b expected 0/1", o_locked, o_edge_error);
          end
        end
        if (g == 2 && c == 4) begin
          tests++;
          if (o_edge_error !== 1'b0) begin fails++; $display("FAIL glitch_err_single: got %b expected 0", o_edge_error); end
        end
        if (g == 6 && c == 2) begin
          tests++;
          if (o_locked !== 1'b0) begin fails++; $display("FAIL glitch_relock_early: got %b expected 0", o_locked); end
        end
        if (g == 6 && c == 3) begin
          tests++;
          if (o_locked !== 1'b1) begin fails++; $display("FAIL glitch_relock: got %b expected 1", o_locked); end
        end
      end
    end
    tests++;
    if (err_cnt !== 1) begin fails++; $display("FAIL glitch_err_count: got %0d expected 1", err_cnt); end
    tests++;
    if (mon_bits.size() !== 5) begin fails++; $display("FAIL glitch_strobe_count: got %0d expected 5", mon_bits.size()); end
    for (int i = 0; i < 5 && i < mon_bits.size(); i++) begin
      tests++;
      if (mon_bits[i] !== exp_bits[i]) begin fails++; $display("FAIL glitch_bit%0d: got %b expected %b", i, mon_bits[i], exp_bits[i]); end
    end
  endtask

  task automatic test_abort();
    // Asynchronous reset in the middle of a half-bit while locked
    i_line = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (o_locked !== 1'b1) begin fails++; $display("FAIL abort_pre_lock: got %b expected 1", o_locked); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({o_bit, valid_out, o_locked, o_edge_error} !== 4'b0000) begin
      fails++; $display("FAIL abort_async_rst: got %b expected 0000", {o_bit, valid_out, o_locked, o_edge_error});
    end
    @(negedge clk);
    rst = 1'b0;
    i_line = 1'b0;
    repeat (3) @(negedge clk);

    // One-cycle enable drop while locked, then relock
    clear_mon();
    for (int t = 0; t < 13; t++) begin
      i_line = (t % 2 == 0) ? 1'b1 : 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (t == 4 && c == 3) begin
          tests++;
          if (o_locked !== 1'b1) begin fails++; $display("FAIL abort_lock: got %b expected 1", o_locked); end
        end
        if (t == 6 && c == 5) i_enable = 1'b0;
        if (t == 6 && c == 6) begin
          tests++;
          if (o_locked !== 1'b0 || o_edge_error !== 1'b0) begin
            fails++; $display("FAIL abort_disable: locked=%b err=%b expected 0/0", o_locked, o_edge_error);
          end
          i_enable = 1'b1;
          clear_mon();
        end
        if (t == 11 && c == 2) begin
          tests++;
          if (o_locked !== 1'b0) begin fails++; $display("FAIL abort_relock_early: got %b expected 0", o_locked); end
        end
        if (t == 11 && c == 3) begin
          tests++;
          if (o_locked !== 1'b1) begin fails++; $display("FAIL abort_relock: got %b expected 1", o_locked); end
        end
      end
    end
    tests++;
    if (err_cnt !== 0) begin fails++; $display("FAIL abort_err_count: got %0d expected 0", err_cnt); end
    tests++;
    if (mon_bits.size() !== 2) begin
      fails++; $display("FAIL abort_strobe_count: got %0d expected 2", mon_bits.size());
    end else begin
      tests++;
      if (mon_bits[0] !== 1'b0 || mon_bits[1] !== 1'b1) begin
        fails++; $display("FAIL abort_bits: got %b%b expected 01", mon_bits[0], mon_bits[1]);
      end
    end
  endtask

  initial begin
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    test_reset();
    test_clean();
    test_dead_line();
    test_jitter();
    test_glitch();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
